// File: rtl/light_sequencer.sv
// Four-phase main-road / country-road light sequencer with a one-second prescaler.
// Optional night mode (flashing yellow) is compiled in with `define LIGHT_SEQ_NIGHT_EN.
module light_sequencer #(
    parameter int unsigned TICK_DIV        = 50_000_000,
    parameter int unsigned MAIN_GREEN_S    = 30,
    parameter int unsigned COUNTRY_GREEN_S = 20,
    parameter int unsigned YELLOW_S        = 3,
    parameter int unsigned FLICKER_S       = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pause,
`ifdef LIGHT_SEQ_NIGHT_EN
    input  logic       night,
`endif
    output logic [1:0] light,
    output logic       flicker,
    output logic [7:0] remain,
    output logic       tick
);

    localparam int unsigned   PW         = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        S_MG,
        S_Y1,
        S_CG,
        S_Y2
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [7:0]    remain_q, remain_d;
    logic [1:0]    light_q, light_d;
    logic          flicker_q, flicker_d;
    logic          tick_q, tick_d;

    function automatic state_t next_state(input state_t s);
        case (s)
            S_MG:    return S_Y1;
            S_Y1:    return S_CG;
            S_CG:    return S_Y2;
            default: return S_MG;
        endcase
    endfunction

    function automatic logic [7:0] duration(input state_t s);
        case (s)
            S_MG:    return 8'(MAIN_GREEN_S);
            S_CG:    return 8'(COUNTRY_GREEN_S);
            default: return 8'(YELLOW_S);
        endcase
    endfunction

    function automatic logic [1:0] light_code(input state_t s);
        case (s)
            S_MG:    return 2'b10;
            S_CG:    return 2'b00;
            default: return 2'b01;
        endcase
    endfunction

    // NOTE: every next-state signal gets a hold default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_d   = state_q;
        presc_d   = presc_q;
        remain_d  = remain_q;
        tick_d    = 1'b0;
        light_d   = light_q;
        flicker_d = flicker_q;
`ifdef LIGHT_SEQ_NIGHT_EN
        if (night) begin
            state_d   = S_MG;
            presc_d   = '0;
            remain_d  = '0;
            light_d   = 2'b01;
            flicker_d = 1'b1;
        end else begin
            // remain is only ever 0 while parked in night mode: restart the main-green phase.
            if (remain_q == '0) begin
                remain_d = 8'(MAIN_GREEN_S);
            end
`else
        begin
`endif
            if (!pause) begin
                if (presc_q == PRESC_LAST) begin
                    presc_d = '0;
                    tick_d  = 1'b1;
                    if (remain_q == 8'd1) begin
                        state_d  = next_state(state_q);
                        remain_d = duration(next_state(state_q));
                    end else begin
                        remain_d = remain_q - 8'd1;
                    end
                end else begin
                    presc_d = presc_q + PW'(1);
                end
            end
            light_d   = light_code(state_d);
            flicker_d = ((state_d == S_MG) || (state_d == S_CG)) && (remain_d <= 8'(FLICKER_S));
        end
    end

    // NOTE: state registers use non-blocking assignments so all of them update together on the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_MG;
            presc_q   <= '0;
            remain_q  <= 8'(MAIN_GREEN_S);
            light_q   <= 2'b10;
            flicker_q <= 1'b0;
            tick_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            presc_q   <= presc_d;
            remain_q  <= remain_d;
            light_q   <= light_d;
            flicker_q <= flicker_d;
            tick_q    <= tick_d;
        end
    end

    assign light   = light_q;
    assign flicker = flicker_q;
    assign remain  = remain_q;
    assign tick    = tick_q;

endmodule
